// File: rtl/decoder_scan_seq_if.sv
// Handshake/control and code bundle between a scan controller and the decoder scanner.
// The master side drives the scan controls, and the slave side returns the code and status.
interface decoder_scan_seq_if #(
    parameter int DWELL_W = 4
);
    logic               start;
    logic               stop;
    logic               dir;
    logic               cont;
    logic [DWELL_W-1:0] dwell;
    logic               A;
    logic               B;
    logic               C;
    logic               busy;
    logic               wrap;
    logic               done;

    modport master (
        output start, stop, dir, cont, dwell,
        input  A, B, C, busy, wrap, done
    );

    modport slave (
        input  start, stop, dir, cont, dwell,
        output A, B, C, busy, wrap, done
    );
endinterface

// File: rtl/decoder_scan_seq.sv
// Steps a 3-bit code {C,B,A} through 0..7 (up or down) for a 3-to-8 decoder.
// Each code is held for dwell+1 cycles, in single-pass or continuous mode.
module decoder_scan_seq #(
    parameter int DWELL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    decoder_scan_seq_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [2:0]         code_r;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               dir_r;
    logic               cont_r;
    logic               busy_r;
    logic               wrap_r;
    logic               done_r;
    logic [2:0]         step_code_s;
    logic               at_wrap_s;

    // Next code in the latched direction, and whether that step crosses the 7/0 boundary
    always_comb begin
        step_code_s = code_r;
        at_wrap_s   = 1'b0;
        if (dir_r) begin
            step_code_s = code_r - 3'd1;
            at_wrap_s   = (code_r == 3'd0);
        end else begin
            step_code_s = code_r + 3'd1;
            at_wrap_s   = (code_r == 3'd7);
        end
    end

    // Scan FSM: state, code, dwell counter, latched configuration and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            code_r  <= 3'd0;
            cnt_r   <= CNT_ZERO;
            dwell_r <= CNT_ZERO;
            dir_r   <= 1'b0;
            cont_r  <= 1'b0;
            busy_r  <= 1'b0;
            wrap_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // stop beats start when both arrive together
                    if (bus.start && !bus.stop) begin
                        state_r <= SCAN;
                        busy_r  <= 1'b1;
                        code_r  <= bus.dir ? 3'd7 : 3'd0;
                        dir_r   <= bus.dir;
                        cont_r  <= bus.cont;
                        dwell_r <= bus.dwell;
                        cnt_r   <= bus.dwell;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SCAN: begin
                    if (bus.stop) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        code_r <= step_code_s;
                        cnt_r  <= dwell_r;
                        if (at_wrap_s) begin
                            wrap_r <= 1'b1;
                            // A single pass ends on its wrap, with the code back at the start value
                            if (!cont_r) begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                busy_r <= 1'b1;
                            end
                        end else begin
                            busy_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A    = code_r[0];
    assign bus.B    = code_r[1];
    assign bus.C    = code_r[2];
    assign bus.busy = busy_r;
    assign bus.wrap = wrap_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_decoder_scan_seq.sv
// Randomized scoreboard bench for decoder_scan_seq; expected outputs come from an
// elapsed-time model of the scan and are checked by a separate monitor process.
module tb_decoder_scan_seq;
    logic clk;
    logic reset;

    decoder_scan_seq_if #(.DWELL_W(4)) bus ();

    decoder_scan_seq #(.DWELL_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] code;
        logic       busy;
        logic       wrap;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model state: scan progress measured as cycles elapsed since the start edge
    bit m_scan = 1'b0;
    int m_t = 0;
    bit m_dir = 1'b0;
    bit m_cont = 1'b0;
    int m_dwell = 0;
    int m_base = 0;
    int m_code = 0;
    bit m_wrap = 1'b0;
    bit m_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic s, input logic p,
                              input logic d, input logic c, input logic [3:0] w);
        exp_t e;
        int   period;
        int   steps;
        if (r) begin
            m_scan = 1'b0;
            m_code = 0;
            m_wrap = 1'b0;
            m_done = 1'b0;
        end else if (!m_scan) begin
            m_wrap = 1'b0;
            m_done = 1'b0;
            if (s && !p) begin
                m_scan  = 1'b1;
                m_t     = 0;
                m_dir   = d;
                m_cont  = c;
                m_dwell = int'(w);
                m_base  = d ? 7 : 0;
                m_code  = m_base;
            end
        end else if (p) begin
            m_scan = 1'b0;
            m_wrap = 1'b0;
            m_done = 1'b0;
        end else begin
            m_t    = m_t + 1;
            period = m_dwell + 1;
            steps  = m_t / period;
            m_code = m_dir ? (((m_base - steps) % 8) + 8) % 8 : (m_base + steps) % 8;
            m_wrap = (m_t % (8 * period)) == 0;
            m_done = m_wrap && !m_cont;
            if (m_done) m_scan = 1'b0;
        end
        e.code = 3'(m_code);
        e.busy = m_scan;
        e.wrap = m_wrap;
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic s, input logic p,
                       input logic d, input logic c, input logic [3:0] w);
        @(negedge clk);
        reset     = r;
        bus.start = s;
        bus.stop  = p;
        bus.dir   = d;
        bus.cont  = c;
        bus.dwell = w;
        model_step(r, s, p, d, c, w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)));
    endtask

    // Monitor: after every active edge, pop the expected response and compare it
    always begin
        exp_t e;
        logic [2:0] code_s;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            code_s = {bus.C, bus.B, bus.A};
            tests_run++;
            if (code_s !== e.code || bus.busy !== e.busy || bus.wrap !== e.wrap || bus.done !== e.done) begin
                tests_failed++;
                $display("FAIL outputs @%0t: got code=%0d busy=%b wrap=%b done=%b, expected code=%0d busy=%b wrap=%b done=%b",
                         $time, code_s, bus.busy, bus.wrap, bus.done, e.code, e.busy, e.wrap, e.done);
            end
        end
    end

    initial begin
        int n;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.dir   = 1'b0;
        bus.cont  = 1'b0;
        bus.dwell = 4'd0;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
        idle(2);

        // single pass up, dwell 0
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(10);

        // single pass down, dwell 2
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
        idle(27);

        // continuous up, dwell 1, then stop while code is 5
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        idle(40);
        n = 0;
        while (m_code != 5 && n < 20) begin
            idle(1);
            n++;
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(3);

        // start and stop together in IDLE
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
        idle(3);

        // stop exactly when the 7->0 wrap is due
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(7);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(3);

        // reset mid-scan at code 3 with start high, then a fresh scan
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        idle(10);

        // maximum dwell, single pass
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
        idle(132);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            cyc(1'($urandom_range(0, 199) == 0),
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 49) == 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) == 0),
                w);
        end
        idle(4);

        repeat (2) @(posedge clk);
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/decoder_scan_seq.md
DECODER_SCAN_SEQ -- requirements
Module: decoder_scan_seq

Interface
REQ-001 Parameter: DWELL_W, default 4, width of the dwell input and the dwell counter.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  begins a scan when sampled high in IDLE.
REQ-005 Port: stop  input  1  aborts a scan when sampled high in SCAN.
REQ-006 Port: dir  input  1  scan direction: 0 counts up 0->7, 1 counts down 7->0; sampled only at start.
REQ-007 Port: cont  input  1  continuous mode when 1, single pass when 0; sampled only at start.
REQ-008 Port: dwell  input  DWELL_W  extra hold cycles per code; sampled only at start.
REQ-009 Port: A  output  1  code bit 0 (LSB), drives the 3-to-8 decoder A input.
REQ-010 Port: B  output  1  code bit 1, drives the decoder B input.
REQ-011 Port: C  output  1  code bit 2 (MSB), drives the decoder C input.
REQ-012 Port: busy  output  1  high while in SCAN.
REQ-013 Port: wrap  output  1  one-cycle pulse on each code wrap.
REQ-014 Port: done  output  1  one-cycle pulse on single-pass completion.
REQ-015 The clock SHALL be the only clock, and reset SHALL be synchronous and active-high.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and SCAN.
REQ-017 All outputs SHALL be registered; code = {C,B,A}.
REQ-018 In IDLE, start=1 and stop=0 SHALL cause these updates at the same edge: enter SCAN; code = 0 if dir=0, else 7; dir, cont and dwell latched; dwell counter = dwell.
REQ-019 In IDLE, start=1 and stop=1 in the same cycle SHALL leave the block in IDLE with no state change (stop wins).
REQ-020 In IDLE, the code SHALL hold its last value.
REQ-021 In SCAN with stop=0 and dwell counter != 0, the dwell counter SHALL decrement and the code SHALL hold.
REQ-022 In SCAN with stop=0 and dwell counter == 0, the code SHALL step by +1 (dir=0) or -1 (dir=1), modulo 8, and the dwell counter SHALL reload the latched dwell.
REQ-023 Each code SHALL therefore be presented for exactly dwell+1 cycles.
REQ-024 A step from 7->0 (up) or 0->7 (down) is a wrap; wrap SHALL be high for exactly the one cycle following that edge.
REQ-025 On a wrap with latched cont=0, the block SHALL, at the same edge, enter IDLE and pulse done for one cycle. The code then equals the start value, and busy SHALL read 0 in that cycle.
REQ-026 A single pass SHALL keep busy high for exactly 8*(dwell+1) cycles.
REQ-027 On a wrap with latched cont=1, the block SHALL remain in SCAN, and done SHALL stay 0.
REQ-028 In SCAN, stop=1 SHALL cause entry to IDLE at the next edge with the code held, no step, and wrap=0 and done=0, even if a step or wrap was due that cycle.
REQ-029 start sampled in SCAN SHALL be ignored.
REQ-030 Changes to dir, cont or dwell during SCAN SHALL have no effect until the next start.
REQ-031 dwell=0 SHALL step the code every cycle.
REQ-032 dwell = 2^DWELL_W-1 SHALL hold each code for 2^DWELL_W cycles without counter overflow.
REQ-033 wrap and done SHALL never be high for more than one consecutive cycle.

Reset
REQ-034 reset=1 at a rising edge SHALL set: state = IDLE; A = B = C = 0; busy = 0; wrap = 0; done = 0; dwell counter = 0; latched dir = 0; latched cont = 0; latched dwell = 0.
REQ-035 reset SHALL take priority over start and stop in the same cycle.
REQ-036 reset asserted mid-scan SHALL abort the scan with no done or wrap pulse.

Verification
REQ-037 Scenario: dwell=0, dir=0, cont=0, start pulse -> code 0,1,...,7 on 8 consecutive cycles with busy=1; the next cycle shows code=0, busy=0, wrap=1, done=1.
REQ-038 Scenario: dwell=2, dir=1, cont=0 -> each code 7..0 held 3 cycles; busy high for 24 cycles; done pulses once.
REQ-039 Scenario: dwell=1, dir=0, cont=1, run 40 cycles -> wrap pulses every 16 cycles; done stays 0; stop asserted while code=5 -> code stays 5 and busy=0 on the next cycle.
REQ-040 Scenario: start and stop both high in IDLE -> busy stays 0 and the code is unchanged.
REQ-041 Scenario: stop asserted in the cycle where the 7->0 wrap is due (cont=0) -> code stays 7, wrap=0, done=0, busy=0.
REQ-042 Scenario: reset asserted at code=3 mid-scan, with start also high -> next cycle shows code=0, busy=0, wrap=0, done=0; a later start begins a fresh scan normally.
